// File: rtl/clk_div_detect_if.sv
// Bundle of the clock-monitor signals for clk_div_detect.
// The master side drives the enable and the clock under measurement; the
// slave side (the detector) returns the measurement results.
interface clk_div_detect_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             clk_in;
    logic [CNT_W-1:0] n_out;
    logic [CNT_W-1:0] high_out;
    logic             valid;
    logic             lock;
    logic             timeout;
    logic             duty_err;

    modport master (
        output en, clk_in,
        input  n_out, high_out, valid, lock, timeout, duty_err
    );

    modport slave (
        input  en, clk_in,
        output n_out, high_out, valid, lock, timeout, duty_err
    );
endinterface

// File: rtl/clk_div_detect.sv
// Divided-clock detector: synchronises clk_in, measures its period and high
// time in clk cycles, raises lock after LOCK_CNT identical periods and pulses
// timeout when no rising edge arrives within 2^CNT_W-1 cycles.
// Optional macro DUTY_CHECK_EN adds a 50%-duty comparator (duty_err) that
// also gates lock; without it duty_err is tied low.
//
// state | meaning
// IDLE  | disabled, counters held at 0
// ARM   | waiting for the first rising edge; counts cycles for timeout
// MEAS  | measuring back-to-back periods, reporting on each rising edge
module clk_div_detect #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    clk_div_detect_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_d, rise;
    logic [CNT_W-1:0]       s_ext;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] per_cnt, per_d;
    logic [CNT_W-1:0] hi_cnt, hi_d;
    logic             capture, to_fire, clr_match;

    logic [CNT_W-1:0] n_q, high_q;
    logic             valid_q, timeout_q;
    logic [3:0]       match_q;
    logic             duty_q;

    assign s     = sync_q[SYNC_STAGES-1];
    assign rise  = s & ~s_d;
    assign s_ext = {{(CNT_W-1){1'b0}}, s};

    // Synchroniser chain plus history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.clk_in};
            s_d    <= s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and counter updates; a rise in the timeout cycle wins
    always_comb begin
        state_d   = state_q;
        per_d     = per_cnt;
        hi_d      = hi_cnt;
        capture   = 1'b0;
        to_fire   = 1'b0;
        clr_match = 1'b0;
        if (!bus.en) begin
            state_d   = IDLE;
            per_d     = '0;
            hi_d      = '0;
            clr_match = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    per_d   = '0;
                    hi_d    = '0;
                end
                ARM: begin
                    if (rise) begin
                        state_d = MEAS;
                        per_d   = CNT_ONE;
                        hi_d    = s_ext;
                    end else if (per_cnt == CNT_MAX) begin
                        to_fire   = 1'b1;
                        clr_match = 1'b1;
                        per_d     = CNT_ONE;
                    end else begin
                        per_d = per_cnt + CNT_ONE;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        capture = 1'b1;
                        per_d   = CNT_ONE;
                        hi_d    = s_ext;
                    end else if (per_cnt == CNT_MAX) begin
                        to_fire   = 1'b1;
                        clr_match = 1'b1;
                        state_d   = ARM;
                        per_d     = CNT_ONE;
                        hi_d      = '0;
                    end else begin
                        per_d = per_cnt + CNT_ONE;
                        hi_d  = hi_cnt + s_ext;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Counters, result registers, pulses and the lock match counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt   <= '0;
            hi_cnt    <= '0;
            n_q       <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            match_q   <= '0;
        end else begin
            per_cnt   <= per_d;
            hi_cnt    <= hi_d;
            valid_q   <= capture;
            timeout_q <= to_fire;
            if (capture) begin
                n_q    <= per_cnt;
                high_q <= hi_cnt;
            end
            if (clr_match) begin
                match_q <= '0;
            end else if (capture) begin
                if (match_q == '0 || per_cnt != n_q)
                    match_q <= 4'd1;
                else if (match_q < LOCK_TGT)
                    match_q <= match_q + 4'd1;
            end
        end
    end

`ifdef DUTY_CHECK_EN
    logic [CNT_W:0]   per_p1;
    logic [CNT_W-1:0] half_lo, half_hi;
    logic             duty_bad;

    assign per_p1   = {1'b0, per_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign half_lo  = per_cnt >> 1;
    assign half_hi  = per_p1[CNT_W:1];
    assign duty_bad = (hi_cnt != half_lo) && (hi_cnt != half_hi);

    // Duty flag refreshes with each new measurement, cleared when disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        duty_q <= 1'b0;
        else if (!bus.en)  duty_q <= 1'b0;
        else if (capture)  duty_q <= duty_bad;
    end
`else
    assign duty_q = 1'b0;
`endif

    assign bus.n_out    = n_q;
    assign bus.high_out = high_q;
    assign bus.valid    = valid_q;
    assign bus.timeout  = timeout_q;
    assign bus.duty_err = duty_q;
    assign bus.lock     = (match_q >= LOCK_TGT) & ~duty_q;
endmodule

// File: tb/tb_clk_div_detect.sv
// Directed bench for clk_div_detect: drives clk_in patterns, pushes the
// expected measurement for each completed period into a scoreboard and
// compares on every valid pulse.
module tb_clk_div_detect;
    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 4;
`ifdef DUTY_CHECK_EN
    localparam bit DUTY_ON = 1'b1;
`else
    localparam bit DUTY_ON = 1'b0;
`endif

    typedef struct {
        int n;
        int h;
        bit lk;
        bit de;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clk_div_detect_if #(.CNT_W(CNT_W)) bus ();

    clk_div_detect #(.CNT_W(CNT_W), .SYNC_STAGES(2), .LOCK_CNT(LOCK_CNT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   m_match = 0;
    int   m_last = 0;
    bit   pend_ok = 1'b0;
    int   pend_n = 0;
    int   pend_h = 0;
    bit   expect_to = 1'b0;
    int   to_count = 0;
    int   cyc = 0;
    int   last_to = -1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected result of the period that a new rising edge closes
    task automatic on_rise(input int n, input int h);
        exp_t e;
        if (pend_ok) begin
            if (m_match == 0 || pend_n != m_last) m_match = 1;
            else if (m_match < LOCK_CNT)          m_match++;
            m_last = pend_n;
            e.n  = pend_n;
            e.h  = pend_h;
            e.de = DUTY_ON && (pend_h != pend_n / 2) && (pend_h != (pend_n + 1) / 2);
            e.lk = (m_match >= LOCK_CNT) && !e.de;
            sb.push_back(e);
        end
        pend_n  = n;
        pend_h  = h;
        pend_ok = 1'b1;
    endtask

    task automatic run(input int hi, input int lo, input int cnt);
        repeat (cnt) begin
            on_rise(hi + lo, hi);
            bus.clk_in = 1'b1;
            repeat (hi) @(negedge clk);
            bus.clk_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic forget_history();
        pend_ok = 1'b0;
        m_match = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_n_out"}, int'(bus.n_out), 0);
        chk({tag, "_high_out"}, int'(bus.high_out), 0);
        chk({tag, "_valid"}, int'(bus.valid), 0);
        chk({tag, "_lock"}, int'(bus.lock), 0);
        chk({tag, "_timeout"}, int'(bus.timeout), 0);
        chk({tag, "_duty_err"}, int'(bus.duty_err), 0);
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard pop on valid, timeout pulse bookkeeping
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.valid) begin
                chk("valid_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("n_out", int'(bus.n_out), e.n);
                    chk("high_out", int'(bus.high_out), e.h);
                    chk("lock", int'(bus.lock), int'(e.lk));
                    chk("duty_err", int'(bus.duty_err), int'(e.de));
                end
            end
            if (bus.timeout) begin
                chk("timeout_allowed", int'(expect_to), 1);
                if (expect_to && last_to >= 0)
                    chk("timeout_interval", cyc - last_to, 255);
                last_to = cyc;
                to_count++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.en     = 1'b0;
        bus.clk_in = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        bus.en = 1'b1;
        repeat (2) @(negedge clk);

        // N=4, 50% duty
        run(2, 2, 8);
        chk("lock_n4", int'(bus.lock), 1);
        // N=5 odd ratio
        run(3, 2, 7);
        // N=6 locked, then switch to N=3
        run(3, 3, 6);
        chk("lock_n6", int'(bus.lock), 1);
        run(2, 1, 7);
        chk("lock_n3", int'(bus.lock), 1);

        // Disable: lock cleared, results held
        bus.en = 1'b0;
        forget_history();
        @(negedge clk);
        @(negedge clk);
        chk("dis_lock", int'(bus.lock), 0);
        chk("dis_n_out_hold", int'(bus.n_out), m_last);
        chk("dis_duty", int'(bus.duty_err), 0);
        bus.en = 1'b1;
        repeat (3) @(negedge clk);

        // Period 8 with high time 1
        run(1, 7, 6);
        chk("duty8_err", int'(bus.duty_err), int'(DUTY_ON));
        chk("duty8_lock", int'(bus.lock), int'(!DUTY_ON));

        // Stalled input: repeating timeouts, no valid, results held
        expect_to = 1'b1;
        to_count  = 0;
        last_to   = -1;
        repeat (800) @(negedge clk);
        expect_to = 1'b0;
        forget_history();
        chk("stall_timeouts", to_count, 3);
        chk("stall_lock", int'(bus.lock), 0);
        chk("stall_n_out_hold", int'(bus.n_out), m_last);

        // Reset in the middle of a period
        run(2, 2, 3);
        bus.clk_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n      = 1'b0;
        bus.clk_in = 1'b0;
        forget_history();
        m_last = 0;
        #1;
        chk_all_zero("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_n_out", int'(bus.n_out), 0);
        run(2, 2, 5);
        chk("post_rst_lock", int'(bus.lock), 1);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
